// File: rtl/ir_cache_pkg.sv
// Shared definitions for the instruction cache: default widths, FSM state
// encodings and a helper for sizing index counters.
package ir_cache_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int IR_ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Bits needed to index a table of 'depth' entries; never less than one.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ir_cache_ram.sv
// Instruction storage: one synchronous write port, one registered read port.
// The read register clears when the read is not enabled, so the owner can
// force the output word to zero; the array itself is never cleared.
module ir_cache_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Array write, only ever driven by the fill handshake.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; zero when disabled or in reset.
  always_ff @(posedge clk) begin
    if (!rst_n || !re) rdata <= '0;
    else               rdata <= mem[raddr];
  end

endmodule

// File: rtl/ir_cache.sv
// Instruction cache: after reset (or a reload request) copies INIT_WORDS
// words from backing memory starting at MEM_BASE, then serves registered
// reads indexed by the decoder's instruction pointer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one-cycle pause before a fill starts
// ST_FILL  | requesting words from backing memory, one per ack
// ST_READY | table valid, reads served, o_init_done high
module ir_cache
  import ir_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int IR_ADDR_WIDTH  = IR_ADDR_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int INIT_WORDS     = 256,
  parameter int MEM_BASE       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_reload,
  output logic                      o_mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  output logic                      o_init_done,
  input  logic [IR_ADDR_WIDTH-1:0]  i_irp,
  output logic [DATA_WIDTH-1:0]     o_data
);

  localparam int AW = idx_width(INIT_WORDS);
  localparam logic [AW-1:0]             LAST_IDX = AW'(INIT_WORDS - 1);
  localparam logic [IR_ADDR_WIDTH:0]    LIMIT    = (IR_ADDR_WIDTH + 1)'(INIT_WORDS);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE     = MEM_ADDR_WIDTH'(MEM_BASE);

  state_t        state;
  logic [AW-1:0] fill_idx;
  logic          wr_en;
  logic          rd_en;

  // An ack coinciding with reset is dropped so an aborted fill writes nothing.
  assign wr_en = rst_n && (state == ST_FILL) && i_mem_ack;

  // A reload request blanks the next output word along with o_init_done.
  assign rd_en = rst_n && (state == ST_READY) && !i_reload &&
                 ({1'b0, i_irp} < LIMIT);

  // Sequencer: fill index, memory request/address and completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fill_idx    <= '0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= BASE;
      o_init_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_FILL;
          fill_idx   <= '0;
          o_mem_req  <= 1'b1;
          o_mem_addr <= BASE;
        end
        ST_FILL: begin
          if (i_mem_ack) begin
            if (fill_idx == LAST_IDX) begin
              // Index holds at the last entry rather than wrapping.
              state       <= ST_READY;
              o_mem_req   <= 1'b0;
              o_init_done <= 1'b1;
            end else begin
              fill_idx   <= fill_idx + 1'b1;
              o_mem_addr <= o_mem_addr + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (i_reload) begin
            state       <= ST_IDLE;
            fill_idx    <= '0;
            o_mem_addr  <= BASE;
            o_init_done <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          fill_idx    <= '0;
          o_mem_req   <= 1'b0;
          o_mem_addr  <= BASE;
          o_init_done <= 1'b0;
        end
      endcase
    end
  end

  ir_cache_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (INIT_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (fill_idx),
    .wdata (i_mem_data),
    .re    (rd_en),
    .raddr (i_irp[AW-1:0]),
    .rdata (o_data)
  );

endmodule

// File: tb/tb_ir_cache.sv
// Bench for ir_cache: a four-word cache filled from base address 16, with a
// behavioural memory responder and a model of the stored words.
module tb_ir_cache;

  localparam int DW   = 8;
  localparam int IAW  = 8;
  localparam int MAW  = 16;
  localparam int NW   = 4;
  localparam int BASE = 16;

  logic           clk        = 1'b0;
  logic           rst_n      = 1'b0;
  logic           i_reload   = 1'b0;
  logic           i_mem_ack  = 1'b0;
  logic [DW-1:0]  i_mem_data = '0;
  logic [IAW-1:0] i_irp      = '0;
  logic           o_mem_req;
  logic [MAW-1:0] o_mem_addr;
  logic           o_init_done;
  logic [DW-1:0]  o_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the words the cache should hold and whether it should be serving.
  logic [DW-1:0] ref_mem [NW];
  bit            m_ready = 1'b0;

  ir_cache #(
    .DATA_WIDTH     (DW),
    .IR_ADDR_WIDTH  (IAW),
    .MEM_ADDR_WIDTH (MAW),
    .INIT_WORDS     (NW),
    .MEM_BASE       (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_reload    (i_reload),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_init_done (o_init_done),
    .i_irp       (i_irp),
    .o_data      (o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!o_mem_req && n < 8) begin
      step();
      n++;
    end
    chk("req_rise", 32'(o_mem_req), 32'd1);
  endtask

  // Serve n_acks words. dmode: 0 data=base+address, 1 random, 2 data=base+index.
  task automatic fill(input int lat_min, input int lat_max, input int dmode,
                      input int base, input int n_acks, input bit rnd_reload);
    for (int k = 0; k < n_acks; k++) begin
      int            lat;
      int            exp_addr;
      logic [DW-1:0] d;
      lat      = $urandom_range(lat_max, lat_min);
      exp_addr = BASE + k;
      for (int w = 0; w < lat; w++) begin
        i_mem_ack = 1'b0;
        i_reload  = rnd_reload ? 1'($urandom_range(1, 0)) : 1'b0;
        chk("addr_wait", 32'(o_mem_addr), 32'(exp_addr));
        chk("req_wait", 32'(o_mem_req), 32'd1);
        chk("done_wait", 32'(o_init_done), 32'd0);
        step();
      end
      if (dmode == 1)      d = DW'($urandom_range(255, 0));
      else if (dmode == 2) d = DW'(base + k);
      else                 d = DW'(base + exp_addr);
      i_reload   = rnd_reload ? 1'($urandom_range(1, 0)) : 1'b0;
      i_mem_ack  = 1'b1;
      i_mem_data = d;
      chk("addr_ack", 32'(o_mem_addr), 32'(exp_addr));
      chk("req_ack", 32'(o_mem_req), 32'd1);
      chk("done_fill", 32'(o_init_done), 32'd0);
      chk("data_fill", 32'(o_data), 32'd0);
      step();
      ref_mem[k] = d;
      i_mem_ack  = 1'b0;
      i_reload   = 1'b0;
    end
    if (n_acks == NW) begin
      m_ready = 1'b1;
      chk("req_after_last", 32'(o_mem_req), 32'd0);
      chk("done_rise", 32'(o_init_done), 32'd1);
    end
  endtask

  task automatic rd(input int irp);
    logic [DW-1:0] exp;
    i_irp = IAW'(irp);
    step();
    exp = (m_ready && irp < NW) ? ref_mem[irp] : '0;
    chk($sformatf("read[%0d]", irp), 32'(o_data), 32'(exp));
    chk("req_ready", 32'(o_mem_req), 32'd0);
  endtask

  task automatic reload();
    i_reload = 1'b1;
    step();
    i_reload = 1'b0;
    m_ready  = 1'b0;
    chk("done_drop", 32'(o_init_done), 32'd0);
    chk("data_reload", 32'(o_data), 32'd0);
    wait_req();
    chk("addr_restart", 32'(o_mem_addr), 32'(BASE));
  endtask

  task automatic spurious_acks(input int n);
    for (int i = 0; i < n; i++) begin
      i_mem_ack  = 1'b1;
      i_mem_data = DW'($urandom_range(255, 0));
      step();
      chk("spur_req", 32'(o_mem_req), 32'd0);
      chk("spur_done", 32'(o_init_done), 32'd1);
    end
    i_mem_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'(BASE));
    chk("rst_done", 32'(o_init_done), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    rst_n = 1'b1;
    wait_req();

    // Back-to-back acks, data 0xA0 + address
    fill(0, 0, 0, 'hA0, NW, 1'b0);
    rd(2);
    rd(7);
    for (int i = 0; i < NW; i++) rd(i);

    // Reset after the second ack, with an ack in the reset cycle
    reload();
    fill(0, 0, 0, 'hA0, 2, 1'b0);
    rst_n      = 1'b0;
    i_mem_ack  = 1'b1;
    i_mem_data = 8'hEE;
    step();
    i_mem_ack = 1'b0;
    m_ready   = 1'b0;
    chk("rst_mid_req", 32'(o_mem_req), 32'd0);
    chk("rst_mid_addr", 32'(o_mem_addr), 32'(BASE));
    chk("rst_mid_done", 32'(o_init_done), 32'd0);
    rst_n = 1'b1;
    wait_req();
    chk("refill_addr", 32'(o_mem_addr), 32'(BASE));
    fill(0, 0, 0, 'hA0, NW, 1'b0);
    for (int i = 0; i < NW; i++) rd(i);

    // Three wait cycles per word, reload pulses during the fill ignored
    reload();
    fill(3, 3, 0, 'h70, NW, 1'b1);
    for (int i = 0; i < NW; i++) rd(i);

    // Reload with new contents 0xC0 + index
    i_irp = 1;
    step();
    reload();
    fill(0, 0, 2, 'hC0, NW, 1'b0);
    rd(1);

    // Spurious acks in READY leave the table alone
    spurious_acks(3);
    for (int i = 0; i < NW; i++) rd(i);

    // Randomized fills and reads
    for (int it = 0; it < 8; it++) begin
      reload();
      fill(0, 3, 1, 0, NW, 1'b1);
      for (int r = 0; r < 6; r++) begin
        rd($urandom_range(7, 0));
        if ($urandom_range(3, 0) == 0) spurious_acks(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
